// File: rtl/mips_pkg.sv
// Shared types and constants for the ID/EX hazard stage.
package mips_pkg;

    localparam int DATA_W = 32;

    // ID_Forward* select encodings; 2'b11 also reads the register file
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_t;

    // Producer with destination p_wesel feeds the ID instruction's sources
    function automatic logic reg_match(
        input logic [4:0] p_wesel,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       uses_rt
    );
        return (p_wesel != 5'd0) && ((p_wesel == rs) || (uses_rt && (p_wesel == rt)));
    endfunction

endpackage

// File: rtl/id_operand_mux.sv
// Forwarding select for both ID operands plus the branch equality compare.
module id_operand_mux
    import mips_pkg::*;
#(
    parameter int DATA_W = mips_pkg::DATA_W
) (
    input  logic [1:0]        fwd_a,
    input  logic [1:0]        fwd_b,
    input  logic [DATA_W-1:0] rf_a,
    input  logic [DATA_W-1:0] rf_b,
    input  logic [DATA_W-1:0] mem_val,
    input  logic [DATA_W-1:0] wb_val,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic              eq
);

    // Per-operand source select; unused encoding falls back to the regfile
    always_comb begin
        case (fwd_a)
            FWD_WB:  op_a = wb_val;
            FWD_MEM: op_a = mem_val;
            default: op_a = rf_a;
        endcase
        case (fwd_b)
            FWD_WB:  op_b = wb_val;
            FWD_MEM: op_b = mem_val;
            default: op_b = rf_b;
        endcase
        eq = (op_a == op_b);
    end

endmodule

// File: rtl/id_ex_hazard_stage.sv
// ID back end: operand forwarding, branch resolution, hazard stall FSM,
// and the ID/EX pipeline register with bubble insertion.
module id_ex_hazard_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int PERF_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ID_valid,
    input  logic [4:0]        ID_rs,
    input  logic [4:0]        ID_rt,
    input  logic              ID_uses_rt,
    input  logic              ID_beq,
    input  logic              ID_bne,
    input  logic [4:0]        ID_Wesel,
    input  logic              ID_RegWrite,
    input  logic              ID_MemRead,
    input  logic [DATA_W-1:0] ID_rf_a,
    input  logic [DATA_W-1:0] ID_rf_b,
    input  logic [1:0]        ID_ForwardA,
    input  logic [1:0]        ID_ForwardB,
    input  logic [DATA_W-1:0] MEM_alu_result,
    input  logic [DATA_W-1:0] WB_wdata,
    input  logic              MEM_MemRead,
    input  logic [4:0]        MEM_Wesel,
    output logic              stall,
    output logic              ID_flush,
    output logic              branch_taken,
    output logic              EX_valid,
    output logic              EX_RegWrite,
    output logic              EX_MemRead,
    output logic [4:0]        EX_Wesel,
    output logic [4:0]        EX_rs,
    output logic [4:0]        EX_rt,
    output logic [DATA_W-1:0] EX_opA,
    output logic [DATA_W-1:0] EX_opB,
    output logic [PERF_W-1:0] stall_cycles
);

    logic [DATA_W-1:0] op_a, op_b;
    logic              ops_eq;

    id_operand_mux #(.DATA_W(DATA_W)) u_mux (
        .fwd_a   (ID_ForwardA),
        .fwd_b   (ID_ForwardB),
        .rf_a    (ID_rf_a),
        .rf_b    (ID_rf_b),
        .mem_val (MEM_alu_result),
        .wb_val  (WB_wdata),
        .op_a    (op_a),
        .op_b    (op_b),
        .eq      (ops_eq)
    );

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              ex_valid_q, ex_valid_d;
    logic              ex_regwrite_q, ex_regwrite_d;
    logic              ex_memread_q, ex_memread_d;
    logic [4:0]        ex_wesel_q, ex_wesel_d;
    logic [4:0]        ex_rs_q, ex_rs_d;
    logic [4:0]        ex_rt_q, ex_rt_d;
    logic [DATA_W-1:0] ex_opa_q, ex_opa_d;
    logic [DATA_W-1:0] ex_opb_q, ex_opb_d;
    logic [PERF_W-1:0] stall_cycles_q, stall_cycles_d;

    logic       is_branch, ex_match, mem_match;
    logic [1:0] need;

    assign is_branch = ID_beq | ID_bne;
    assign ex_match  = reg_match(ex_wesel_q, ID_rs, ID_rt, ID_uses_rt);
    assign mem_match = reg_match(MEM_Wesel, ID_rs, ID_rt, ID_uses_rt);

    // Stall cycles required by the ID instruction, largest case first
    always_comb begin
        need = 2'd0;
        if (ID_valid) begin
            if (is_branch) begin
                if (ex_memread_q && ex_match)       need = 2'd2;
                else if (ex_regwrite_q && ex_match) need = 2'd1;
                else if (MEM_MemRead && mem_match)  need = 2'd1;
            end else if (ex_memread_q && ex_match) begin
                need = 2'd1;
            end
        end
    end

    // Stall FSM: hazards are only sampled in IDLE; STALL counts down
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        case (state_q)
            IDLE: begin
                if (need != 2'd0) begin
                    stall   = 1'b1;
                    cnt_d   = need - 2'd1;
                    // a single-cycle stall stays in IDLE and re-evaluates
                    state_d = (need > 2'd1) ? STALL : IDLE;
                end
            end
            STALL: begin
                stall = 1'b1;
                cnt_d = cnt_q - 2'd1;
                if (cnt_q <= 2'd1) begin
                    cnt_d   = 2'd0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 2'd0;
            end
        endcase
    end

    // Branch resolves only once all stalls have cleared
    always_comb begin
        branch_taken = !stall && ID_valid && ((ID_beq && ops_eq) || (ID_bne && !ops_eq));
        ID_flush     = branch_taken;
    end

    // ID/EX next values: bubble when stalled or ID empty
    always_comb begin
        ex_valid_d    = 1'b0;
        ex_regwrite_d = 1'b0;
        ex_memread_d  = 1'b0;
        ex_wesel_d    = 5'd0;
        ex_rs_d       = 5'd0;
        ex_rt_d       = 5'd0;
        ex_opa_d      = '0;
        ex_opb_d      = '0;
        if (!stall && ID_valid) begin
            ex_valid_d    = 1'b1;
            ex_regwrite_d = ID_RegWrite;
            ex_memread_d  = ID_MemRead;
            ex_wesel_d    = ID_Wesel;
            ex_rs_d       = ID_rs;
            ex_rt_d       = ID_rt;
            ex_opa_d      = op_a;
            ex_opb_d      = op_b;
        end
    end

    // Saturating stall-cycle counter
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall && !(&stall_cycles_q))
            stall_cycles_d = stall_cycles_q + 1'b1;
    end

    // All state, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= 2'd0;
            ex_valid_q     <= 1'b0;
            ex_regwrite_q  <= 1'b0;
            ex_memread_q   <= 1'b0;
            ex_wesel_q     <= 5'd0;
            ex_rs_q        <= 5'd0;
            ex_rt_q        <= 5'd0;
            ex_opa_q       <= '0;
            ex_opb_q       <= '0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            ex_valid_q     <= ex_valid_d;
            ex_regwrite_q  <= ex_regwrite_d;
            ex_memread_q   <= ex_memread_d;
            ex_wesel_q     <= ex_wesel_d;
            ex_rs_q        <= ex_rs_d;
            ex_rt_q        <= ex_rt_d;
            ex_opa_q       <= ex_opa_d;
            ex_opb_q       <= ex_opb_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign EX_valid     = ex_valid_q;
    assign EX_RegWrite  = ex_regwrite_q;
    assign EX_MemRead   = ex_memread_q;
    assign EX_Wesel     = ex_wesel_q;
    assign EX_rs        = ex_rs_q;
    assign EX_rt        = ex_rt_q;
    assign EX_opA       = ex_opa_q;
    assign EX_opB       = ex_opb_q;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Directed bench for id_ex_hazard_stage.
module tb_id_ex_hazard_stage;

    localparam int DATA_W = 32;
    localparam int PERF_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              ID_valid, ID_uses_rt, ID_beq, ID_bne, ID_RegWrite, ID_MemRead;
    logic [4:0]        ID_rs, ID_rt, ID_Wesel, MEM_Wesel;
    logic [DATA_W-1:0] ID_rf_a, ID_rf_b, MEM_alu_result, WB_wdata;
    logic [1:0]        ID_ForwardA, ID_ForwardB;
    logic              MEM_MemRead;
    logic              stall, ID_flush, branch_taken;
    logic              EX_valid, EX_RegWrite, EX_MemRead;
    logic [4:0]        EX_Wesel, EX_rs, EX_rt;
    logic [DATA_W-1:0] EX_opA, EX_opB;
    logic [PERF_W-1:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    id_ex_hazard_stage #(.DATA_W(DATA_W), .PERF_W(PERF_W)) dut (
        .clk(clk), .rst(rst),
        .ID_valid(ID_valid), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rt(ID_uses_rt),
        .ID_beq(ID_beq), .ID_bne(ID_bne), .ID_Wesel(ID_Wesel),
        .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead),
        .ID_rf_a(ID_rf_a), .ID_rf_b(ID_rf_b),
        .ID_ForwardA(ID_ForwardA), .ID_ForwardB(ID_ForwardB),
        .MEM_alu_result(MEM_alu_result), .WB_wdata(WB_wdata),
        .MEM_MemRead(MEM_MemRead), .MEM_Wesel(MEM_Wesel),
        .stall(stall), .ID_flush(ID_flush), .branch_taken(branch_taken),
        .EX_valid(EX_valid), .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead),
        .EX_Wesel(EX_Wesel), .EX_rs(EX_rs), .EX_rt(EX_rt),
        .EX_opA(EX_opA), .EX_opB(EX_opB), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_id();
        ID_valid = 0; ID_rs = 0; ID_rt = 0; ID_uses_rt = 0;
        ID_beq = 0; ID_bne = 0; ID_Wesel = 0; ID_RegWrite = 0; ID_MemRead = 0;
        ID_rf_a = 0; ID_rf_b = 0; ID_ForwardA = 2'b00; ID_ForwardB = 2'b00;
        MEM_alu_result = 0; WB_wdata = 0; MEM_MemRead = 0; MEM_Wesel = 0;
    endtask

    task automatic do_reset();
        clear_id();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    initial begin
        rst = 1;
        clear_id();

        // ---- reset state
        do_reset();
        settle();
        chk("rst_ex_valid", EX_valid, 0);
        chk("rst_ex_opa", EX_opA, 0);
        chk("rst_stall_cycles", stall_cycles, 0);
        chk("rst_stall", stall, 0);

        // ---- load-use: lw r2 in EX, add reading r2
        ID_valid = 1; ID_MemRead = 1; ID_RegWrite = 1; ID_Wesel = 5'd2; ID_rs = 5'd1;
        ID_rf_a = 32'h100;
        settle();
        chk("lw_no_stall", stall, 0);
        tick();
        chk("lw_ex_valid", EX_valid, 1);
        chk("lw_ex_memread", EX_MemRead, 1);
        chk("lw_ex_wesel", EX_Wesel, 2);
        chk("lw_ex_opa", EX_opA, 32'h100);
        clear_id();
        ID_valid = 1; ID_rs = 5'd2; ID_rt = 5'd4; ID_uses_rt = 1; ID_RegWrite = 1;
        ID_Wesel = 5'd5; ID_rf_a = 32'hAAAA;
        settle();
        chk("lu_stall", stall, 1);
        tick();
        chk("lu_bubble_valid", EX_valid, 0);
        chk("lu_bubble_wesel", EX_Wesel, 0);
        chk("lu_bubble_opa", EX_opA, 0);
        chk("lu_stall_cycles", stall_cycles, 1);
        ID_ForwardA = 2'b10; MEM_alu_result = 32'h1234;
        settle();
        chk("lu_stall_released", stall, 0);
        tick();
        chk("lu_fwd_valid", EX_valid, 1);
        chk("lu_fwd_opa", EX_opA, 32'h1234);
        chk("lu_fwd_rs", EX_rs, 2);
        chk("lu_fwd_rt", EX_rt, 4);
        chk("lu_fwd_regwrite", EX_RegWrite, 1);

        // ---- lw r3 in EX then beq rs=3: two stall cycles
        do_reset();
        ID_valid = 1; ID_MemRead = 1; ID_RegWrite = 1; ID_Wesel = 5'd3;
        tick();
        clear_id();
        ID_valid = 1; ID_beq = 1; ID_rs = 5'd3; ID_rt = 5'd6; ID_uses_rt = 1;
        ID_rf_a = 32'h5; ID_rf_b = 32'h5;
        settle();
        chk("br2_stall_c1", stall, 1);
        chk("br2_flush_c1", ID_flush, 0);
        tick();
        chk("br2_bubble", EX_valid, 0);
        MEM_MemRead = 1; MEM_Wesel = 5'd3;
        settle();
        chk("br2_stall_c2", stall, 1);
        chk("br2_flush_c2", ID_flush, 0);
        tick();
        chk("br2_stall_cycles", stall_cycles, 2);
        MEM_MemRead = 0; MEM_Wesel = 0;
        ID_ForwardA = 2'b10; MEM_alu_result = 32'h5;
        settle();
        chk("br2_stall_c3", stall, 0);
        chk("br2_flush_c3", ID_flush, 1);
        chk("br2_taken_c3", branch_taken, 1);
        tick();
        chk("br2_branch_in_ex", EX_valid, 1);
        chk("br2_ex_opa", EX_opA, 32'h5);
        ID_valid = 0;
        settle();
        chk("br2_flush_pulse", ID_flush, 0);

        // ---- bne with WB forwarding on B
        clear_id();
        ID_valid = 1; ID_bne = 1; ID_rs = 5'd7; ID_rt = 5'd8; ID_uses_rt = 1;
        ID_ForwardB = 2'b01; WB_wdata = 32'h10; ID_rf_a = 32'h10; ID_rf_b = 32'h77;
        settle();
        chk("bne_equal", branch_taken, 0);
        ID_rf_a = 32'h11;
        settle();
        chk("bne_differ", branch_taken, 1);
        chk("bne_flush", ID_flush, 1);
        ID_ForwardB = 2'b11; ID_rf_b = 32'h11;
        settle();
        chk("bne_fwd11_rf", branch_taken, 0);
        tick();
        chk("bne_ex_opa", EX_opA, 32'h11);
        chk("bne_ex_opb", EX_opB, 32'h11);

        // ---- producer writing r0 never causes a stall
        clear_id();
        ID_valid = 1; ID_MemRead = 1; ID_Wesel = 5'd0;
        tick();
        chk("r0_ex_memread", EX_MemRead, 1);
        chk("r0_ex_wesel", EX_Wesel, 0);
        clear_id();
        ID_valid = 1; ID_rs = 5'd0; ID_rt = 5'd0; ID_uses_rt = 1;
        settle();
        chk("r0_alu_no_stall", stall, 0);
        ID_beq = 1;
        settle();
        chk("r0_br_no_stall", stall, 0);

        // ---- reset in the second cycle of a 2-cycle stall
        do_reset();
        ID_valid = 1; ID_MemRead = 1; ID_RegWrite = 1; ID_Wesel = 5'd3;
        tick();
        clear_id();
        ID_valid = 1; ID_beq = 1; ID_rs = 5'd3; ID_rf_a = 32'h1; ID_rf_b = 32'h2;
        settle();
        chk("rs_stall_c1", stall, 1);
        tick();
        rst = 1;
        settle();
        chk("rs_stall_c2", stall, 1);
        tick();
        chk("rs_stall_after", stall, 0);
        chk("rs_ex_valid", EX_valid, 0);
        chk("rs_ex_memread", EX_MemRead, 0);
        chk("rs_ex_regwrite", EX_RegWrite, 0);
        chk("rs_ex_wesel", EX_Wesel, 0);
        chk("rs_ex_opa", EX_opA, 0);
        chk("rs_stall_cycles", stall_cycles, 0);
        rst = 0;

        // ---- counter saturation: branch waiting on a MEM load every cycle
        do_reset();
        ID_valid = 1; ID_beq = 1; ID_rs = 5'd9; MEM_MemRead = 1; MEM_Wesel = 5'd9;
        repeat (65534) tick();
        chk("sat_fffe", stall_cycles, 16'hFFFE);
        tick();
        chk("sat_ffff", stall_cycles, 16'hFFFF);
        repeat (70000 - 65535) tick();
        chk("sat_hold", stall_cycles, 16'hFFFF);
        chk("sat_still_stall", stall, 1);
        chk("sat_bubble", EX_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
